water_level_sampler: RTL and testbench

Input-side reader for the three reservoir level switches. It debounces each raw switch and checks that the debounced vector is a valid thermometer pattern. It then publishes a registered 2-bit level code, a persistent conflict flag and level-change events. It replaces direct use of raw switch lines by the irrigation controller, alarm controller and water-level matrix decoder.

---
 rtl/water_level_sampler.sv | 187 ++++++++++++++++++
 tb/tb_water_level_sampler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/water_level_sampler.sv
// Debounced reader for the three reservoir level switches: validates the thermometer
// pattern, publishes a 2-bit level code, a persistent conflict flag and change events.
`timescale 1ns/1ps

module water_level_sampler #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CONFLICT_HOLD   = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_sample_enable,
    input  logic       i_low_water_level,
    input  logic       i_mid_water_level,
    input  logic       i_high_water_level,
    output logic [2:0] o_stable_levels,
    output logic [1:0] o_encoded_water,
    output logic       o_level_valid,
    output logic       o_conflicting_values,
    output logic       o_level_changed,
    output logic       o_level_rising
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]    INIT_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]    HOLD_LAST = 8'(CONFLICT_HOLD - 1);

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        VALID   = 2'd1,
        SUSPECT = 2'd2,
        FAULT   = 2'd3
    } state_t;

    logic [2:0]    w_raw;
    logic [2:0]    r_stable;
    logic [DW-1:0] r_db_cnt [3];

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       w_load;
    logic       w_pattern_valid;
    logic [1:0] w_mapped;

    logic [1:0] r_encoded;
    logic [1:0] r_encoded_d;
    logic       r_changed;
    logic       r_rising;

    assign w_raw = {i_high_water_level, i_mid_water_level, i_low_water_level};

    // The stable bit flips on the edge where the disagreement count would hit DEBOUNCE_CYCLES.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_stable <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else if (i_sample_enable) begin
            for (int i = 0; i < 3; i++) begin
                if (w_raw[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_stable[i] <= ~r_stable[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_pattern_valid = 1'b1;
        w_mapped        = 2'b00;
        case (r_stable)
            3'b000:  w_mapped = 2'b00;
            3'b001:  w_mapped = 2'b01;
            3'b011:  w_mapped = 2'b10;
            3'b111:  w_mapped = 2'b11;
            default: w_pattern_valid = 1'b0;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= INIT;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // r_cnt is shared: settling count in INIT, invalid run in SUSPECT, valid run in FAULT.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        if (i_sample_enable) begin
            case (r_state)
                INIT: begin
                    if (r_cnt == INIT_LAST) begin
                        if (w_pattern_valid) begin
                            w_state_next = VALID;
                            w_cnt_next   = 8'd0;
                            w_load       = 1'b1;
                        end else if (CONFLICT_HOLD == 1) begin
                            w_state_next = FAULT;
                            w_cnt_next   = 8'd0;
                        end else begin
                            w_state_next = SUSPECT;
                            w_cnt_next   = 8'd1;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
                VALID: begin
                    if (w_pattern_valid) begin
                        w_load = 1'b1;
                    end else if (CONFLICT_HOLD == 1) begin
                        w_state_next = FAULT;
                        w_cnt_next   = 8'd0;
                    end else begin
                        w_state_next = SUSPECT;
                        w_cnt_next   = 8'd1;
                    end
                end
                SUSPECT: begin
                    if (w_pattern_valid) begin
                        w_state_next = VALID;
                        w_cnt_next   = 8'd0;
                        w_load       = 1'b1;
                    end else if (r_cnt == HOLD_LAST) begin
                        w_state_next = FAULT;
                        w_cnt_next   = 8'd0;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
                FAULT: begin
                    if (!w_pattern_valid) begin
                        w_cnt_next = 8'd0;
                    end else if (r_cnt == HOLD_LAST) begin
                        w_state_next = VALID;
                        w_cnt_next   = 8'd0;
                        w_load       = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_next = INIT;
                    w_cnt_next   = 8'd0;
                end
            endcase
        end
    end

    // Change events compare the code against its one-cycle-old copy, so they trail the code by a cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_encoded   <= 2'b00;
            r_encoded_d <= 2'b00;
            r_changed   <= 1'b0;
            r_rising    <= 1'b0;
        end else begin
            if (w_load) begin
                r_encoded <= w_mapped;
            end
            r_encoded_d <= r_encoded;
            r_changed   <= (r_encoded != r_encoded_d);
            r_rising    <= (r_encoded > r_encoded_d);
        end
    end

    assign o_stable_levels      = r_stable;
    assign o_encoded_water      = r_encoded;
    assign o_level_valid        = (r_state == VALID) || (r_state == SUSPECT);
    assign o_conflicting_values = (r_state == FAULT);
    assign o_level_changed      = r_changed;
    assign o_level_rising       = r_rising;

endmodule

// File: tb/tb_water_level_sampler.sv
// Directed bench for water_level_sampler; level-change events are checked against
// a queue of expected {code, rising} entries pushed as each stimulus step is applied.
`timescale 1ns/1ps

module tb_water_level_sampler;

    typedef struct packed {
        logic [1:0] code;
        logic       rising;
    } event_t;

    logic       clock;
    logic       reset;
    logic       sampleEnable;
    logic       lowLevel;
    logic       midLevel;
    logic       highLevel;
    logic [2:0] stableLevels;
    logic [1:0] encodedWater;
    logic       levelValid;
    logic       conflicting;
    logic       levelChanged;
    logic       levelRising;

    int     checkCount = 0;
    int     errorCount = 0;
    event_t expectedQ[$];

    water_level_sampler #(
        .DEBOUNCE_CYCLES(8),
        .CONFLICT_HOLD  (4)
    ) dut (
        .i_clock             (clock),
        .i_reset             (reset),
        .i_sample_enable     (sampleEnable),
        .i_low_water_level   (lowLevel),
        .i_mid_water_level   (midLevel),
        .i_high_water_level  (highLevel),
        .o_stable_levels     (stableLevels),
        .o_encoded_water     (encodedWater),
        .o_level_valid       (levelValid),
        .o_conflicting_values(conflicting),
        .o_level_changed     (levelChanged),
        .o_level_rising      (levelRising)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] raw, input logic en);
        {highLevel, midLevel, lowLevel} = raw;
        sampleEnable = en;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expectEvent(input logic [1:0] code, input logic rising);
        event_t e;
        e.code   = code;
        e.rising = rising;
        expectedQ.push_back(e);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_stable"},   {5'd0, stableLevels}, 8'h00);
        checkOutput({tag, "_encoded"},  {6'd0, encodedWater}, 8'h00);
        checkOutput({tag, "_valid"},    {7'd0, levelValid},   8'h00);
        checkOutput({tag, "_conflict"}, {7'd0, conflicting},  8'h00);
        checkOutput({tag, "_changed"},  {7'd0, levelChanged}, 8'h00);
        checkOutput({tag, "_rising"},   {7'd0, levelRising},  8'h00);
    endtask

    // Scoreboard side: every change pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (levelChanged === 1'b1) begin
            if (expectedQ.size() == 0) begin
                checkOutput("unexpected_pulse", {7'd0, levelChanged}, 8'h00);
            end else begin
                event_t e;
                e = expectedQ.pop_front();
                checkOutput("event_code",   {6'd0, encodedWater}, {6'd0, e.code});
                checkOutput("event_rising", {7'd0, levelRising},  {7'd0, e.rising});
            end
        end else begin
            checkOutput("rising_idle", {7'd0, levelRising}, 8'h00);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(3'b000, 1'b0);
        step(2);
        checkResetState("reset");

        // First settle from reset with raw = 001.
        reset = 1'b0;
        applyStimulus(3'b001, 1'b1);
        expectEvent(2'b01, 1'b1);
        step(7);
        checkOutput("settle_c7_stable", {5'd0, stableLevels}, 8'h00);
        checkOutput("settle_c7_valid",  {7'd0, levelValid},   8'h00);
        step(1);
        checkOutput("settle_c8_stable", {5'd0, stableLevels}, 8'h01);
        checkOutput("settle_c8_valid",  {7'd0, levelValid},   8'h01);
        checkOutput("settle_c8_code",   {6'd0, encodedWater}, 8'h00);
        step(1);
        checkOutput("settle_c9_code",   {6'd0, encodedWater}, 8'h01);
        checkOutput("settle_c9_changed", {7'd0, levelChanged}, 8'h00);
        step(1);
        checkOutput("settle_c10_changed", {7'd0, levelChanged}, 8'h01);
        checkOutput("settle_c10_rising",  {7'd0, levelRising},  8'h01);

        // Step up to 011, then a 5-cycle mid glitch that must be filtered.
        applyStimulus(3'b011, 1'b1);
        expectEvent(2'b10, 1'b1);
        step(8);
        checkOutput("mid_stable", {5'd0, stableLevels}, 8'h03);
        checkOutput("mid_code_before", {6'd0, encodedWater}, 8'h01);
        step(1);
        checkOutput("mid_code", {6'd0, encodedWater}, 8'h02);
        step(2);
        applyStimulus(3'b001, 1'b1);
        step(5);
        applyStimulus(3'b011, 1'b1);
        step(10);
        checkOutput("glitch_stable", {5'd0, stableLevels}, 8'h03);
        checkOutput("glitch_code",   {6'd0, encodedWater}, 8'h02);

        // Invalid 101 walks through SUSPECT into FAULT.
        applyStimulus(3'b101, 1'b1);
        step(8);
        checkOutput("bad_stable", {5'd0, stableLevels}, 8'h05);
        step(1);
        checkOutput("suspect_valid",    {7'd0, levelValid},  8'h01);
        checkOutput("suspect_conflict", {7'd0, conflicting}, 8'h00);
        step(2);
        checkOutput("suspect3_conflict", {7'd0, conflicting}, 8'h00);
        step(1);
        checkOutput("fault_conflict", {7'd0, conflicting},  8'h01);
        checkOutput("fault_valid",    {7'd0, levelValid},   8'h00);
        checkOutput("fault_code",     {6'd0, encodedWater}, 8'h02);

        // Recovery to 111 needs debounce plus four valid samples.
        applyStimulus(3'b111, 1'b1);
        expectEvent(2'b11, 1'b1);
        step(8);
        checkOutput("recov_stable",   {5'd0, stableLevels}, 8'h07);
        checkOutput("recov_conflict", {7'd0, conflicting},  8'h01);
        step(3);
        checkOutput("recov3_conflict", {7'd0, conflicting}, 8'h01);
        step(1);
        checkOutput("recov4_conflict", {7'd0, conflicting},  8'h00);
        checkOutput("recov4_valid",    {7'd0, levelValid},   8'h01);
        checkOutput("recov4_code",     {6'd0, encodedWater}, 8'h03);
        step(3);

        // Re-enter FAULT, then show short valid runs keep clearing the recovery count.
        applyStimulus(3'b101, 1'b1);
        step(12);
        checkOutput("refault_conflict", {7'd0, conflicting},  8'h01);
        checkOutput("refault_code",     {6'd0, encodedWater}, 8'h03);
        applyStimulus(3'b111, 1'b1);
        step(2);
        applyStimulus(3'b110, 1'b1);
        step(10);
        checkOutput("altA_stable",   {5'd0, stableLevels}, 8'h06);
        checkOutput("altA_conflict", {7'd0, conflicting},  8'h01);
        applyStimulus(3'b111, 1'b1);
        step(2);
        applyStimulus(3'b101, 1'b1);
        step(10);
        checkOutput("altB_stable",   {5'd0, stableLevels}, 8'h05);
        checkOutput("altB_conflict", {7'd0, conflicting},  8'h01);
        applyStimulus(3'b111, 1'b1);
        step(11);
        checkOutput("exit3_conflict", {7'd0, conflicting}, 8'h01);
        step(1);
        checkOutput("exit_conflict", {7'd0, conflicting},  8'h00);
        checkOutput("exit_code",     {6'd0, encodedWater}, 8'h03);
        step(3);

        // Sparse sampling: one enabled tick every fourth cycle, 111 -> 011.
        expectEvent(2'b10, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(3'b011, 1'b1);
            step(1);
            applyStimulus(3'b011, 1'b0);
            if (k == 7) checkOutput("sparse_k7_stable", {5'd0, stableLevels}, 8'h07);
            if (k == 8) begin
                checkOutput("sparse_k8_stable", {5'd0, stableLevels}, 8'h03);
                checkOutput("sparse_k8_code",   {6'd0, encodedWater}, 8'h03);
            end
            if (k == 9) checkOutput("sparse_k9_code", {6'd0, encodedWater}, 8'h02);
            step(3);
        end

        // Reset in the middle of a debounce discards the partial count.
        applyStimulus(3'b111, 1'b1);
        step(5);
        reset = 1'b1;
        step(1);
        checkResetState("midreset");
        reset = 1'b0;
        expectEvent(2'b11, 1'b1);
        step(7);
        checkOutput("rearm_c7_stable", {5'd0, stableLevels}, 8'h00);
        step(1);
        checkOutput("rearm_c8_stable", {5'd0, stableLevels}, 8'h07);
        step(1);
        checkOutput("rearm_c9_code", {6'd0, encodedWater}, 8'h03);
        step(4);

        checkOutput("queue_drained", 8'(expectedQ.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
